// File: rtl/soml_bit_packer.sv
// Packs 12-bit SOML symbols ({b1,b2}) MSB-first into OUT_W-bit words behind a small
// FIFO, with a flush that emits the zero-padded residue tagged by m_last/m_nbits.
module soml_bit_packer #(
  parameter  int OUT_W = 32,
  parameter  int DEPTH = 8,
  localparam int NB_W  = $clog2(OUT_W) + 1,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       b1,
  input  logic [3:0]       b2,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic [NB_W-1:0]  m_nbits,
  output logic             m_last,
  output logic             flush_done,
  output logic             overflow,
  output logic [LVL_W-1:0] fifo_level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int ACC_W = OUT_W + 11;
  localparam int CNT_W = $clog2(OUT_W + 12);
  localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(OUT_W);

  logic [11:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] acc_cnt;
  logic             flush_pend;

  logic             fifo_empty;
  logic             fifo_full;
  logic             slot_free;
  logic             do_pop;
  logic             do_push;
  logic             do_emit;
  logic             do_service;
  logic [ACC_W-1:0] load_bits;

  // Valid bits live MSB-aligned in acc; everything below acc_cnt is kept zero.
  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == LVL_W'(DEPTH));
  assign slot_free  = !m_valid || m_ready;
  assign do_pop     = !fifo_empty && (acc_cnt < WORD_CNT);
  assign do_push    = in_valid && (!fifo_full || do_pop);
  assign do_emit    = (acc_cnt >= WORD_CNT) && slot_free;
  assign do_service = flush_pend && fifo_empty && (acc_cnt < WORD_CNT) && slot_free;
  assign load_bits  = {mem[rd_ptr], {(ACC_W-12){1'b0}}} >> acc_cnt;

  // A full FIFO with a pop in the same cycle reads the old entry before it is overwritten.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {b1, b2};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (in_valid && !do_push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      acc_cnt    <= '0;
      flush_pend <= 1'b0;
      flush_done <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_nbits    <= '0;
      m_last     <= 1'b0;
    end else begin
      flush_done <= do_service;

      if (do_service)  flush_pend <= 1'b0;
      else if (flush)  flush_pend <= 1'b1;

      if (do_pop) begin
        acc     <= acc | load_bits;
        acc_cnt <= acc_cnt + CNT_W'(12);
      end else if (do_emit) begin
        acc     <= acc << OUT_W;
        acc_cnt <= acc_cnt - WORD_CNT;
      end else if (do_service) begin
        acc     <= '0;
        acc_cnt <= '0;
      end

      // A fresh word may replace the one being accepted in the same cycle.
      if (do_emit) begin
        m_valid <= 1'b1;
        m_data  <= acc[ACC_W-1 -: OUT_W];
        m_nbits <= NB_W'(OUT_W);
        m_last  <= 1'b0;
      end else if (do_service && (acc_cnt != '0)) begin
        m_valid <= 1'b1;
        m_data  <= acc[ACC_W-1 -: OUT_W];
        m_nbits <= NB_W'(acc_cnt);
        m_last  <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_soml_bit_packer.sv
// Self-checking bench for soml_bit_packer: directed scenarios plus randomized rounds
// scored against a bit-queue model of the MSB-first packing stream.
module tb_soml_bit_packer;

  localparam int OUT_W = 32;
  localparam int DEPTH = 8;
  localparam int NB_W  = $clog2(OUT_W) + 1;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       b1 = '0;
  logic [3:0]       b2 = '0;
  logic             flush = 1'b0;
  logic             m_ready = 1'b0;
  logic             m_valid;
  logic [OUT_W-1:0] m_data;
  logic [NB_W-1:0]  m_nbits;
  logic             m_last;
  logic             flush_done;
  logic             overflow;
  logic [LVL_W-1:0] fifo_level;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic [NB_W-1:0]  nbits;
    logic             last;
  } word_t;

  word_t captured[$];
  bit    model_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  soml_bit_packer #(.OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .b1(b1), .b2(b2), .flush(flush),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_nbits(m_nbits),
    .m_last(m_last), .flush_done(flush_done), .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Words handed over at the coming edge are recorded mid-cycle.
  always @(negedge clk) begin
    word_t w;
    if (rst_n && m_valid && m_ready) begin
      w.data  = m_data;
      w.nbits = m_nbits;
      w.last  = m_last;
      captured.push_back(w);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] x1, input logic [3:0] x2,
                               input logic fl);
    in_valid = v;
    b1       = x1;
    b2       = x2;
    flush    = fl;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic pushModel(input logic [7:0] x1, input logic [3:0] x2);
    logic [11:0] s;
    s = {x1, x2};
    for (int i = 11; i >= 0; i--) model_q.push_back(s[i]);
  endtask

  task automatic sendSym(input logic [7:0] x1, input logic [3:0] x2);
    applyStimulus(1'b1, x1, x2, 1'b0);
    pushModel(x1, x2);
  endtask

  function automatic logic [OUT_W-1:0] peekWord(input int n);
    logic [OUT_W-1:0] w;
    w = '0;
    for (int i = 0; i < OUT_W; i++) w = {w[OUT_W-2:0], (i < n) ? model_q[i] : 1'b0};
    return w;
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_m_valid"},    64'(m_valid),    64'(0));
    checkOutput({tag, "_m_data"},     64'(m_data),     64'(0));
    checkOutput({tag, "_m_nbits"},    64'(m_nbits),    64'(0));
    checkOutput({tag, "_m_last"},     64'(m_last),     64'(0));
    checkOutput({tag, "_flush_done"}, 64'(flush_done), 64'(0));
    checkOutput({tag, "_overflow"},   64'(overflow),   64'(0));
    checkOutput({tag, "_fifo_level"}, 64'(fifo_level), 64'(0));
  endtask

  // Takes the next delivered word and scores it against the head of the bit stream.
  task automatic checkWord(input string tag);
    int    waited = 0;
    int    n;
    word_t w;
    while (captured.size() == 0 && waited < 200) begin
      tick();
      waited++;
    end
    if (captured.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("[TB] FAIL %s: no word after %0d cycles, required one word", tag, waited);
    end else begin
      w = captured.pop_front();
      n = (model_q.size() >= OUT_W) ? OUT_W : model_q.size();
      checkOutput({tag, "_data"},  64'(w.data),  64'(peekWord(n)));
      checkOutput({tag, "_nbits"}, 64'(w.nbits), 64'(n));
      checkOutput({tag, "_last"},  64'(w.last),  64'(n < OUT_W));
      repeat (n) void'(model_q.pop_front());
    end
  endtask

  // Issues a flush on a drained packer and checks done timing and the residue word.
  task automatic flushAndCheck(input string tag);
    int               n;
    int               waited = 0;
    logic [OUT_W-1:0] exp_w;
    n     = model_q.size();
    exp_w = peekWord(n);
    applyStimulus(1'b0, 8'h00, 4'h0, 1'b1);
    checkOutput({tag, "_done_early"}, 64'(flush_done), 64'(0));
    while (!flush_done && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput({tag, "_done_latency"}, 64'(waited), 64'(1));
    checkOutput({tag, "_valid"}, 64'(m_valid), 64'(n > 0));
    if (n > 0) begin
      checkOutput({tag, "_data"},  64'(m_data),  64'(exp_w));
      checkOutput({tag, "_nbits"}, 64'(m_nbits), 64'(n));
      checkOutput({tag, "_last"},  64'(m_last),  64'(1));
    end
    tick();
    checkOutput({tag, "_done_pulse"}, 64'(flush_done), 64'(0));
    if (n > 0) checkWord({tag, "_word"});
    else       checkOutput({tag, "_no_word"}, 64'(captured.size()), 64'(0));
  endtask

  task automatic drainAndCheck(input string tag);
    int exp_words;
    m_ready = 1'b1;
    repeat (60) tick();
    exp_words = model_q.size() / OUT_W;
    checkOutput({tag, "_count"}, 64'(captured.size()), 64'(exp_words));
    for (int i = 0; i < exp_words; i++) checkWord($sformatf("%s_w%0d", tag, i));
  endtask

  initial begin
    logic [7:0] x1;
    logic [3:0] x2;

    #2;
    checkAllZero("reset_init");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    checkAllZero("post_reset");

    // A5,3 / 0F,C / FF,9 pack into A530FCFF with the nibble 9 left over.
    m_ready = 1'b1;
    sendSym(8'hA5, 4'h3);
    sendSym(8'h0F, 4'hC);
    sendSym(8'hFF, 4'h9);
    checkOutput("fw_expect_const", 64'(peekWord(OUT_W)), 64'(32'hA530FCFF));
    checkWord("full_word");
    flushAndCheck("flush_residue");
    flushAndCheck("flush_empty");

    // Stalled output, one symbol every 4 cycles: 14 fit, the 15th is dropped.
    m_ready = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      x1 = 8'($urandom);
      x2 = 4'($urandom);
      applyStimulus(1'b1, x1, x2, 1'b0);
      if (k <= 14) pushModel(x1, x2);
      repeat (3) tick();
      if (k == 4) begin
        checkOutput("bp_hold_valid", 64'(m_valid), 64'(1));
        checkOutput("bp_hold_data_early", 64'(m_data), 64'(peekWord(OUT_W)));
      end
      if (k == 14) begin
        checkOutput("bp_level_14", 64'(fifo_level), 64'(DEPTH));
        checkOutput("bp_overflow_14", 64'(overflow), 64'(0));
      end
    end
    checkOutput("bp_overflow_15", 64'(overflow), 64'(1));
    checkOutput("bp_level_15", 64'(fifo_level), 64'(DEPTH));
    checkOutput("bp_hold_data_late", 64'(m_data), 64'(peekWord(OUT_W)));
    checkOutput("bp_hold_nbits", 64'(m_nbits), 64'(OUT_W));
    checkOutput("bp_hold_last", 64'(m_last), 64'(0));

    // Release: first edge emits, second edge pops while the FIFO is full.
    m_ready = 1'b1;
    tick();
    x1 = 8'($urandom);
    x2 = 4'($urandom);
    sendSym(x1, x2);
    checkOutput("full_pop_level", 64'(fifo_level), 64'(DEPTH));
    checkOutput("full_pop_overflow", 64'(overflow), 64'(1));
    drainAndCheck("bp_drain");
    flushAndCheck("bp_flush");

    // Reset while a word is waiting discards all state.
    m_ready = 1'b0;
    for (int k = 0; k < 3; k++) sendSym(8'($urandom), 4'($urandom));
    repeat (3) tick();
    checkOutput("mid_reset_pre_valid", 64'(m_valid), 64'(1));
    #3 rst_n = 1'b0;
    #1 checkAllZero("mid_reset");
    tick();
    rst_n = 1'b1;
    model_q.delete();
    captured.delete();
    m_ready = 1'b1;
    repeat (10) tick();
    checkOutput("mid_reset_no_stale", 64'(captured.size()), 64'(0));
    checkOutput("mid_reset_valid", 64'(m_valid), 64'(0));
    checkOutput("mid_reset_overflow", 64'(overflow), 64'(0));

    // Random traffic with random backpressure, kept clear of overflow.
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 200; c++) begin
        m_ready = ($urandom_range(0, 3) != 0);
        if (($urandom_range(0, 2) == 0) && (int'(fifo_level) < DEPTH - 1))
          sendSym(8'($urandom), 4'($urandom));
        else
          tick();
      end
      drainAndCheck($sformatf("rnd%0d", r));
      flushAndCheck($sformatf("rnd%0d_flush", r));
    end
    checkOutput("rnd_overflow", 64'(overflow), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/soml_bit_packer.md
Name: soml_bit_packer

Overview:
- Sits directly downstream of the SOML output mapping stage.
- Accepts one 12-bit detected-symbol bitfield per in_valid pulse ({b1[7:0], b2[3:0]}) and buffers it in a small FIFO, because upstream has no backpressure.
- Packs the bits MSB-first into OUT_W-bit words and presents them on a valid/ready output interface.
- A flush request emits the final partial word, zero-padded and tagged with last and a bit count.

Parameters:
- OUT_W, 32, output word width in bits; legal range is ≥12.
- DEPTH, 8, symbol FIFO depth in entries; must be a power of 2, ≥2.
- NB_W, $clog2(OUT_W)+1, localparam; width of m_nbits.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  single-cycle strobe; b1/b2 are valid in this cycle.
- b1  in  8  symbol index bits; transmitted first, b1[7] first.
- b2  in  4  symbol constellation bits; follows b1, b2[3] first.
- flush  in  1  pulse; requests emission of the residual bits.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept; a transfer occurs when m_valid && m_ready.
- m_data  out  OUT_W  packed word; first-received bit is at the MSB.
- m_nbits  out  NB_W  count of meaningful bits in m_data (OUT_W for full words).
- m_last  out  1  marks the flush-generated partial word.
- flush_done  out  1  one-cycle pulse when a flush completes.
- overflow  out  1  sticky; a symbol was dropped because the FIFO was full.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, rst_n low):
  - All outputs are 0: m_valid, m_data, m_nbits, m_last, flush_done, overflow, fifo_level.
  - FIFO pointers, accumulator, acc_cnt and flush_pend are all cleared.
  - A reset mid-transfer discards everything, including a pending flush.
- FIFO write: on in_valid, if not full, or full with a pop in the same cycle, the entry {b1,b2} is written.
  - Otherwise the symbol is dropped and overflow is set to 1; it clears only on reset.
  - Read-before-write semantics apply when full with a simultaneous pop.
- Accumulator: OUT_W+11 bits with acc_cnt ranging 0..OUT_W+11.
  - Load (pop): when the FIFO is non-empty and acc_cnt < OUT_W, the 12 bits are appended below the existing bits and acc_cnt += 12.
  - Emit: when acc_cnt ≥ OUT_W and the output slot is free (m_valid==0, or m_valid&&m_ready this cycle):
    - m_data takes the top OUT_W bits, m_nbits=OUT_W, m_last=0, m_valid=1.
    - Remaining bits shift up and acc_cnt -= OUT_W.
  - Load and emit are mutually exclusive by construction; at most one of them happens per cycle.
  - m_valid drops after acceptance unless a new word is emitted in that same cycle.
- Latency: an in_valid at edge t makes the FIFO non-empty for cycle t+1, and the load occurs at edge t+1. A full word becomes visible on m_valid one cycle after the load that crosses OUT_W.
- Output stability: while m_valid && !m_ready, m_data, m_nbits and m_last hold constant.
- Flush handling:
  - A flush pulse sets flush_pend; flush pulses while flush_pend=1 are ignored.
  - The flush is serviced when flush_pend && FIFO empty && acc_cnt < OUT_W && output slot free.
  - If acc_cnt > 0: emit the acc bits MSB-aligned, zero-padded, with m_nbits=acc_cnt and m_last=1; clear acc_cnt and flush_pend; pulse flush_done in the same cycle m_valid rises.
  - If acc_cnt == 0: no word is emitted; clear flush_pend and pulse flush_done.
  - Symbols arriving before service are included in the flush.
  - A flush and an in_valid in the same cycle: the symbol is included.
- Throughput: up to 12 bits per cycle in. The FIFO absorbs back-to-back in_valid bursts of up to DEPTH entries while output stalls.

Test Plan:
- Reset: drive rst_n=0 mid-stream with m_valid=1 -> all outputs read 0 immediately; after release, no stale word appears and overflow=0.
- Full word (OUT_W=32): symbols (b1,b2) = (A5,3), (0F,C), (FF,9), m_ready=1 -> one word m_data=32'hA530FCFF, m_nbits=32, m_last=0; acc_cnt=4 remains.
- Flush residue: after the previous scenario, pulse flush -> m_data=32'h90000000, m_nbits=4, m_last=1, flush_done pulses in the same cycle.
- Empty flush: pulse flush with the FIFO empty and acc_cnt=0 -> flush_done pulses one cycle after the pulse; m_valid stays 0.
- Backpressure/overflow: hold m_ready=0 and send one symbol every 4 cycles:
  - The 1st word is held stable.
  - 14 symbols are accepted: 6 absorbed into the output register and accumulator, 8 in the FIFO.
  - The 15th symbol sets overflow=1 and fifo_level=8.
  - After releasing m_ready, the words drain in order with no data corruption.
- Full FIFO plus simultaneous pop: in_valid while full in the same cycle a load pops -> the write is accepted, overflow is unchanged, fifo_level stays DEPTH.
